// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: board-game status controller sequencing play states, counting moves
// and tracking the best winning step count since reset.
module game_ctrl_fsm #(
    parameter int STEP_W     = 14,
    parameter int STEP_MAX   = 9999,
    parameter bit WRAP_MODE  = 1'b0,
    parameter int MOVE_LIMIT = 0
) (
    input  logic              clk_d,
    input  logic              rst,
    input  logic              start_sw,
    input  logic              pause_sw,
    input  logic              win_flag,
    input  logic              ini_flag,
    input  logic              active,
    input  logic              time_up,
    output logic [2:0]        game_status,
    output logic [STEP_W-1:0] step_number,
    output logic              step_ovf,
    output logic              timer_en,
    output logic              timer_clr,
    output logic [STEP_W-1:0] best_steps,
    output logic              new_record
);
    localparam logic [2:0] CHOSE_BOARD  = 3'd0;
    localparam logic [2:0] GAME_INITIAL = 3'd1;
    localparam logic [2:0] GAMING       = 3'd2;
    localparam logic [2:0] PAUSED       = 3'd3;
    localparam logic [2:0] WINNED       = 3'd4;
    localparam logic [2:0] LOST         = 3'd5;

    logic [2:0] state, next_state;
    logic       win_first, limit_hit, counting, at_max, better;

    assign game_status = state;
    assign limit_hit   = (MOVE_LIMIT != 0) && (int'(step_number) >= MOVE_LIMIT);
    assign counting    = (state == GAME_INITIAL || state == GAMING) && active;
    assign at_max      = step_number == STEP_W'(STEP_MAX);
    assign better      = win_first && step_number < best_steps;

    always_comb begin
        next_state = CHOSE_BOARD;
        if (start_sw)
            case (state)
                CHOSE_BOARD:  next_state = GAME_INITIAL;
                GAME_INITIAL: next_state = win_flag ? WINNED : ini_flag ? GAMING : GAME_INITIAL;
                GAMING:       next_state = win_flag ? WINNED : (time_up || limit_hit) ? LOST :
                                           pause_sw ? PAUSED : GAMING;
                PAUSED:       next_state = pause_sw ? PAUSED : GAMING;
                WINNED:       next_state = WINNED;
                LOST:         next_state = LOST;
                default:      next_state = CHOSE_BOARD;
            endcase
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state       <= CHOSE_BOARD;
            step_number <= '0;
            best_steps  <= STEP_W'(STEP_MAX);
            step_ovf    <= 1'b0;
            timer_en    <= 1'b0;
            timer_clr   <= 1'b0;
            win_first   <= 1'b0;
            new_record  <= 1'b0;
        end else begin
            state     <= next_state;
            step_ovf  <= counting && at_max;
            timer_en  <= state == GAME_INITIAL || state == GAMING;
            timer_clr <= next_state == GAME_INITIAL && state != GAME_INITIAL;
            // flags the first cycle in WINNED so the record compare happens once per win
            win_first  <= next_state == WINNED && state != WINNED;
            new_record <= better;
            if (better)
                best_steps <= step_number;
            if (state == CHOSE_BOARD)
                step_number <= '0;
            else if (counting)
                step_number <= at_max ? (WRAP_MODE ? '0 : step_number) : step_number + STEP_W'(1);
        end
    end
endmodule
